// File: rtl/sipo_shift_reg8.sv
// 8-bit serial-in/parallel-out shift register used as the LFSR state register.
// Optional parallel load behind macro SIPO_PARALLEL_LOAD_EN (absent by default).
`timescale 1ns/1ns

module sipo_shift_reg8 #(
  parameter int unsigned           WIDTH       = 8,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0,
  parameter int unsigned           CLK2Q_DLY   = 0
) (
  input  logic             sin,
  input  logic             clk,
  input  logic             rs,
`ifdef SIPO_PARALLEL_LOAD_EN
  input  logic             ld,
  input  logic [WIDTH-1:0] Pi,
`endif
  output logic [WIDTH-1:0] Po
);

  // CLK2Q_DLY only shapes simulation timing elsewhere; the registers here are zero-delay.
  if (CLK2Q_DLY > 32'd1000) begin : g_clk2q_range
  end

  logic [WIDTH-1:0] r_po;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_next;

  // Shift toward bit 0: new bit enters at the top, old Po[0] falls off.
  assign w_shift = {sin, r_po[WIDTH-1:1]};

`ifdef SIPO_PARALLEL_LOAD_EN
  always_comb begin
    w_next = w_shift;
    if (ld) begin
      w_next = Pi;
    end
  end
`else
  always_comb begin
    w_next = w_shift;
  end
`endif

  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      r_po <= RESET_VALUE;
    end else begin
      r_po <= w_next;
    end
  end

  assign Po = r_po;

endmodule

// File: tb/tb_sipo_shift_reg8.sv
// Directed self-checking bench for sipo_shift_reg8, including an LFSR loop
// with XOR/NAND feedback from taps Po[0], Po[3], Po[6], Po[7].
`timescale 1ns/1ns

module tb_sipo_shift_reg8;

  logic       clk;
  logic       rs;
  logic       sin_drv;
  logic       sin;
  logic       lfsr_mode;
  logic       p;
  logic [7:0] Po;
`ifdef SIPO_PARALLEL_LOAD_EN
  logic       ld;
  logic [7:0] Pi;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0] fill_exp [8] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
  logic [7:0] drain_exp[8] = '{8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};
  logic [7:0] pat_4d   = 8'b0100_1101;
  logic [7:0] pat_a5   = 8'hA5;
  logic [7:0] ref_po;
  logic       ref_fb;

  assign sin = lfsr_mode ? ~(p & (Po[0] ^ Po[3] ^ Po[6] ^ Po[7])) : sin_drv;

  sipo_shift_reg8 #(
    .WIDTH      (8),
    .RESET_VALUE(8'h00),
    .CLK2Q_DLY  (0)
  ) dut (
    .sin(sin),
    .clk(clk),
    .rs (rs),
`ifdef SIPO_PARALLEL_LOAD_EN
    .ld (ld),
    .Pi (Pi),
`endif
    .Po (Po)
  );

  initial begin
    clk = 1'b0;
    forever #100 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] exp);
    checks++;
    assert (Po === exp) else begin
      errors++;
      $error("FAIL %s: Po=%h expected %h", tag, Po, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rs        = 1'b1;
    sin_drv   = 1'b1;
    lfsr_mode = 1'b0;
    p         = 1'b0;
`ifdef SIPO_PARALLEL_LOAD_EN
    ld        = 1'b0;
    Pi        = 8'h00;
`endif
    #1;
    check("reset_initial", 8'h00);

    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("reset_hold_%0d", i), 8'h00);
    end

    rs = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("fill_%0d", i), fill_exp[i]);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("stay_ff_%0d", i), 8'hFF);
    end

    sin_drv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("drain_%0d", i), drain_exp[i]);
    end

    for (int i = 0; i < 8; i++) begin
      sin_drv = pat_4d[i];
      tick();
    end
    check("pattern_4d", 8'h4D);

    for (int i = 0; i < 8; i++) begin
      sin_drv = pat_a5[i];
      tick();
    end
    check("pattern_a5", 8'hA5);

    // Asynchronous reset 30 ns after the edge, no clock involved.
    #29;
    rs = 1'b1;
    #1;
    check("async_reset_mid", 8'h00);
    #10;
    rs      = 1'b0;
    sin_drv = 1'b1;
    tick();
    check("after_release", 8'h80);
    tick();
    check("second_shift", 8'hC0);

    // rs rises in the same time step as a rising edge: reset must win.
    @(posedge clk);
    rs = 1'b1;
    #1;
    check("reset_at_edge", 8'h00);
    tick();
    check("reset_ignores_edge", 8'h00);

`ifdef SIPO_PARALLEL_LOAD_EN
    rs = 1'b0;
    ld = 1'b1;
    Pi = 8'h3C;
    tick();
    check("par_load", 8'h3C);
    ld      = 1'b0;
    sin_drv = 1'b1;
    tick();
    check("shift_after_load", 8'h9E);
    rs = 1'b1;
    #1;
    check("reset_before_lfsr", 8'h00);
`endif

    // LFSR integration: one period in reset already elapsed, then p=0, then p=1.
    lfsr_mode = 1'b1;
    p         = 1'b0;
    ref_po    = 8'h00;
    rs        = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i == 2) p = 1'b1;
      ref_fb = ~(p & (ref_po[0] ^ ref_po[3] ^ ref_po[6] ^ ref_po[7]));
      ref_po = {ref_fb, ref_po[7:1]};
      tick();
      check($sformatf("lfsr_%0d", i), ref_po);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
